// File: rtl/regfile_ctrl_pkg.sv
// Shared types and instruction field layout for the register-file sequencer.
// Every instruction is decoded with these positions, so change them here only.
package regfile_ctrl_pkg;

  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_WIDTH  = 1;
  localparam int INSTR_WIDTH = 16;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int DST_BIT  = 12;
  localparam int SRCA_BIT = 11;
  localparam int SRCB_BIT = 10;
  localparam int RSVD_MSB = 9;
  localparam int RSVD_LSB = 8;
  localparam int IMM_MSB  = 7;
  localparam int IMM_LSB  = 0;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_MOV = 3'd6,
    OP_LDI = 3'd7
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic opcode_t instr_op(input logic [INSTR_WIDTH-1:0] ins);
    return opcode_t'(ins[OP_MSB:OP_LSB]);
  endfunction

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake, register-file ports and status of the sequencer.
// The master modport is the sequencer; the slave modport is the source/register-file side.
interface regfile_sequencer_if
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
);

  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;

  logic [ADDR_W-1:0]  rf_read_register1;
  logic [ADDR_W-1:0]  rf_read_register2;
  logic [DATA_W-1:0]  rf_read_data1;
  logic [DATA_W-1:0]  rf_read_data2;
  logic               rf_write_enable;
  logic [ADDR_W-1:0]  rf_write_register;
  logic [DATA_W-1:0]  rf_write_data;

  logic               done;
  logic [DATA_W-1:0]  result;
  logic               flag_zero;
  logic               flag_carry;
  logic               busy;

  modport master (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_register1, rf_read_register2,
           rf_write_enable, rf_write_register, rf_write_data,
           done, result, flag_zero, flag_carry, busy
  );

  modport slave (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_register1, rf_read_register2,
           rf_write_enable, rf_write_register, rf_write_data,
           done, result, flag_zero, flag_carry, busy
  );

endinterface

// File: rtl/regfile_ctrl_alu.sv
// Combinational ALU: one extra result bit carries ADD carry-out or SUB borrow,
// logic/move/load ops leave it clear.
module regfile_ctrl_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic              carry,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_MOV:  wide = {1'b0, a};
      OP_LDI:  wide = {1'b0, imm};
      default: wide = '0;
    endcase
  end

  assign carry  = wide[DATA_W];
  assign result = wide[DATA_W-1:0];

endmodule

// File: rtl/regfile_sequencer.sv
// Three-state micro-op controller: accept one instruction, read both operands,
// register the ALU result and write it back through the single write port.
//
// state | meaning
// IDLE  | ready for an instruction, read addresses follow the incoming fields
// EXEC  | operands read from latched srcA/srcB, result and flags registered
// WB    | write strobe (unless NOP) and done pulse
module regfile_sequencer
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int ADDR_W  = ADDR_WIDTH,
  parameter int INSTR_W = INSTR_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  regfile_sequencer_if.master bus
);

  state_t             state;
  logic [INSTR_W-1:0] instr_q;
  logic               we_q;
  logic               done_q;
  logic [DATA_W-1:0]  result_q;
  logic               zero_q;
  logic               carry_q;

  opcode_t            op_q;
  logic               ready;
  logic               accept;
  logic               alu_carry;
  logic [DATA_W-1:0]  alu_result;
  logic               unused_rsvd;

  assign op_q        = instr_op(instr_q);
  assign ready       = (state == ST_IDLE) && !reset;
  assign accept      = bus.instr_valid && ready;
  assign unused_rsvd = ^instr_q[RSVD_MSB:RSVD_LSB];

  regfile_ctrl_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (bus.rf_read_data1),
    .b      (bus.rf_read_data2),
    .imm    (instr_q[IMM_MSB:IMM_LSB]),
    .carry  (alu_carry),
    .result (alu_result)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      instr_q  <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            instr_q <= bus.instr;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state  <= ST_WB;
          done_q <= 1'b1;
          // NOP retires without touching result, flags or the register file
          if (op_q != OP_NOP) begin
            we_q     <= 1'b1;
            result_q <= alu_result;
            zero_q   <= (alu_result == '0);
            carry_q  <= alu_carry;
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready       = ready;
  assign bus.busy              = (state != ST_IDLE);
  assign bus.rf_read_register1 = (state == ST_IDLE) ? bus.instr[SRCA_BIT -: ADDR_W]
                                                    : instr_q[SRCA_BIT -: ADDR_W];
  assign bus.rf_read_register2 = (state == ST_IDLE) ? bus.instr[SRCB_BIT -: ADDR_W]
                                                    : instr_q[SRCB_BIT -: ADDR_W];
  // a reset cycle must never commit a write, even if it lands mid-WB
  assign bus.rf_write_enable   = we_q && !reset;
  assign bus.rf_write_register = instr_q[DST_BIT -: ADDR_W];
  assign bus.rf_write_data     = result_q;
  assign bus.done              = done_q;
  assign bus.result            = result_q;
  assign bus.flag_zero         = zero_q;
  assign bus.flag_carry        = carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a 2x8 register file model
// (reset contents r0 = 0x05, r1 = 0x01) and hand-computed expectations.
module tb_regfile_sequencer;
  import regfile_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic rf_load;
  logic [7:0] rf [0:1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_done = 0;
  int n_we = 0;
  int n_acc = 0;

  regfile_sequencer_if sif ();

  regfile_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif)
  );

  always #5 clock = ~clock;

  assign sif.rf_read_data1 = rf[sif.rf_read_register1];
  assign sif.rf_read_data2 = rf[sif.rf_read_register2];

  always @(posedge clock) begin
    if (rf_load) begin
      rf[0] <= 8'h05;
      rf[1] <= 8'h01;
    end else if (sif.rf_write_enable) begin
      rf[sif.rf_write_register] <= sif.rf_write_data;
    end
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (sif.done) n_done <= n_done + 1;
    if (sif.rf_write_enable) n_we <= n_we + 1;
    if (sif.instr_valid && sif.instr_ready) n_acc <= n_acc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction and check the EXEC and WB cycles plus retire values.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic exp_we,
                           input logic [7:0] exp_res, input logic exp_z, input logic exp_c);
    int n;
    n = 0;
    sif.instr = ins;
    sif.instr_valid = 1'b1;
    @(negedge clock);
    while (!sif.instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, ":accept"}, 32'(sif.instr_ready), 32'd1);
    @(posedge clock); #1;
    sif.instr_valid = 1'b0;
    @(negedge clock);
    chk({tag, ":exec_busy"},  32'(sif.busy), 32'd1);
    chk({tag, ":exec_ready"}, 32'(sif.instr_ready), 32'd0);
    chk({tag, ":exec_done"},  32'(sif.done), 32'd0);
    chk({tag, ":exec_we"},    32'(sif.rf_write_enable), 32'd0);
    chk({tag, ":exec_ra1"},   32'(sif.rf_read_register1), 32'(ins[11]));
    chk({tag, ":exec_ra2"},   32'(sif.rf_read_register2), 32'(ins[10]));
    @(negedge clock);
    chk({tag, ":wb_done"}, 32'(sif.done), 32'd1);
    chk({tag, ":wb_we"},   32'(sif.rf_write_enable), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ":wb_wreg"},  32'(sif.rf_write_register), 32'(ins[12]));
      chk({tag, ":wb_wdata"}, 32'(sif.rf_write_data), 32'(exp_res));
    end
    chk({tag, ":result"}, 32'(sif.result), 32'(exp_res));
    chk({tag, ":zero"},   32'(sif.flag_zero), 32'(exp_z));
    chk({tag, ":carry"},  32'(sif.flag_carry), 32'(exp_c));
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] prog [0:2];
    int acc_cyc [0:2];
    int acc0, done0, we0, n;

    reset = 1'b1;
    rf_load = 1'b1;
    sif.instr_valid = 1'b0;
    sif.instr = 16'h0000;

    @(negedge clock);
    chk("rst:ready_low", 32'(sif.instr_ready), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    rf_load = 1'b0;
    @(negedge clock);
    chk("rst:ready",  32'(sif.instr_ready), 32'd1);
    chk("rst:busy",   32'(sif.busy), 32'd0);
    chk("rst:done",   32'(sif.done), 32'd0);
    chk("rst:we",     32'(sif.rf_write_enable), 32'd0);
    chk("rst:result", 32'(sif.result), 32'd0);
    chk("rst:zero",   32'(sif.flag_zero), 32'd0);
    chk("rst:carry",  32'(sif.flag_carry), 32'd0);
    @(posedge clock); #1;

    // ADD r0,r0,r1 : 5+1
    run_instr("add", 16'h2400, 1'b1, 8'h06, 1'b0, 1'b0);
    chk("add:r0", 32'(rf[0]), 32'h06);
    // SUB r1,r1,r0 : 1-6 borrows
    run_instr("sub", 16'h5800, 1'b1, 8'hFB, 1'b0, 1'b1);
    chk("sub:r1", 32'(rf[1]), 32'hFB);

    @(posedge clock); #1; rf_load = 1'b1;
    @(posedge clock); #1; rf_load = 1'b0;

    run_instr("ldi_ff", 16'hE0FF, 1'b1, 8'hFF, 1'b0, 1'b0);
    run_instr("add_wrap", 16'h2400, 1'b1, 8'h00, 1'b1, 1'b1);
    chk("add_wrap:r0", 32'(rf[0]), 32'h00);

    we0 = n_we;
    run_instr("nop", 16'h1FFF, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("nop:no_write", 32'(n_we - we0), 32'd0);
    chk("nop:r1", 32'(rf[1]), 32'h01);

    run_instr("xor", 16'hBC00, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("xor:r1", 32'(rf[1]), 32'h00);
    run_instr("ldi_3c", 16'hF03C, 1'b1, 8'h3C, 1'b0, 1'b0);
    run_instr("or_rsvd", 16'h8700, 1'b1, 8'h3C, 1'b0, 1'b0);
    run_instr("ldi_96", 16'hF096, 1'b1, 8'h96, 1'b0, 1'b0);
    run_instr("and", 16'h64AA, 1'b1, 8'h14, 1'b0, 1'b0);
    run_instr("mov_rsvd", 16'hD300, 1'b1, 8'h14, 1'b0, 1'b0);
    chk("mov:r1", 32'(rf[1]), 32'h14);

    // back-to-back: valid held high across three instructions
    prog[0] = 16'hE010;
    prog[1] = 16'hF020;
    prog[2] = 16'h2400;
    acc0 = n_acc;
    done0 = n_done;
    we0 = n_we;
    sif.instr = prog[0];
    sif.instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (n_acc == acc0 + k && n < 20) begin
        @(posedge clock); #1;
        n++;
      end
      acc_cyc[k] = cyc;
      if (k < 2) sif.instr = prog[k+1];
      else sif.instr_valid = 1'b0;
    end
    repeat (3) @(posedge clock);
    #1;
    chk("b2b:accepts", 32'(n_acc - acc0), 32'd3);
    chk("b2b:dones",   32'(n_done - done0), 32'd3);
    chk("b2b:writes",  32'(n_we - we0), 32'd3);
    chk("b2b:gap01",   32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    chk("b2b:gap12",   32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
    chk("b2b:r0",      32'(rf[0]), 32'h30);
    chk("b2b:r1",      32'(rf[1]), 32'h20);

    // reset during WB of ADD r0,r0,r1 (0x30 + 0xF0 carries)
    run_instr("ldi_f0", 16'hF0F0, 1'b1, 8'hF0, 1'b0, 1'b0);
    we0 = n_we;
    sif.instr = 16'h2400;
    sif.instr_valid = 1'b1;
    @(negedge clock);
    chk("rstwb:ready", 32'(sif.instr_ready), 32'd1);
    @(posedge clock); #1;
    sif.instr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("rstwb:we_gated", 32'(sif.rf_write_enable), 32'd0);
    chk("rstwb:result_pre", 32'(sif.result), 32'h20);
    chk("rstwb:carry_pre", 32'(sif.flag_carry), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rstwb:busy",   32'(sif.busy), 32'd0);
    chk("rstwb:ready2", 32'(sif.instr_ready), 32'd1);
    chk("rstwb:done",   32'(sif.done), 32'd0);
    chk("rstwb:we",     32'(sif.rf_write_enable), 32'd0);
    chk("rstwb:result", 32'(sif.result), 32'd0);
    chk("rstwb:zero",   32'(sif.flag_zero), 32'd0);
    chk("rstwb:carry",  32'(sif.flag_carry), 32'd0);
    chk("rstwb:no_write", 32'(n_we - we0), 32'd0);
    chk("rstwb:r0", 32'(rf[0]), 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Micro-op controller that sequences the 2-entry × 8-bit register file.
- Accepts one 16-bit instruction per valid/ready handshake, drives both read addresses, computes an ALU result and writes it back through the single write port.
- Sits between the instruction source (testbench or future fetch unit) and the register file. It is the only master of the register file ports.

Parameters:
- DATA_W, 8, register and ALU datapath width.
- ADDR_W, 1, register address width (2 registers).
- INSTR_W, 16, instruction width; fixed field layout below.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instruction available
- instr_ready  out  1  controller can accept an instruction
- instr  in  INSTR_W  op[15:13], dst[12], srcA[11], srcB[10], rsvd[9:8], imm[7:0]
- rf_read_register1  out  ADDR_W  register file read port 1 address (srcA)
- rf_read_register2  out  ADDR_W  register file read port 2 address (srcB)
- rf_read_data1  in  DATA_W  register file read data 1 (combinational)
- rf_read_data2  in  DATA_W  register file read data 2 (combinational)
- rf_write_enable  out  1  register file write strobe
- rf_write_register  out  ADDR_W  write address (dst)
- rf_write_data  out  DATA_W  write data
- done  out  1  one-cycle pulse: instruction retired
- result  out  DATA_W  last computed value, held until the next retire
- flag_zero  out  1  result == 0
- flag_carry  out  1  carry or borrow
- busy  out  1  not in IDLE

Behaviour:
- Opcodes:
  - 0 NOP
  - 1 ADD A+B
  - 2 SUB A-B
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 MOV (result = A)
  - 7 LDI (result = imm)
- Reserved bits are ignored.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready = 1. When instr_valid & instr_ready, latch instr and go to EXEC.
  - EXEC: read addresses are driven from the latched srcA/srcB. ALU result, zero and carry are computed from rf_read_data1/2 and registered. Go to WB.
  - WB: rf_write_enable = 1 for all ops except NOP, with dst address and the registered result. done = 1. result and flags update. Go to IDLE.
- Latency and throughput: the write lands on the clock edge ending WB, 2 cycles after the accept edge. Throughput is one instruction per 3 cycles.
- instr_ready is 0 in EXEC and WB. instr_valid held during that time is not consumed. The instruction source must hold instr stable until accepted.
- Read addresses in IDLE are driven from the incoming instr fields (don't-care for the datapath).
- Arithmetic is done at DATA_W+1 bits:
  - ADD: carry = bit DATA_W of the sum.
  - SUB: carry = borrow (1 when A < B unsigned). The result wraps modulo 2^DATA_W.
  - AND/OR/XOR/MOV/LDI: carry is cleared.
  - flag_zero updates on every op except NOP.
- NOP: no write, done still pulses, result and flags are unchanged.
- dst equal to srcA/srcB is legal. Reads in EXEC see the pre-write value.
- Reset, any cycle: the next state is IDLE. rf_write_enable is gated with !reset, so no write occurs in a reset cycle.
- Reset values:
  - done, rf_write_enable: 0
  - result: 0
  - flag_zero, flag_carry: 0
  - busy: 0
  - instr_ready: 1 from the first cycle after reset deasserts (0 while reset is high)
  - the latched instruction: 0 (NOP)

Decomposition:
- Shared package regfile_ctrl_pkg:
  - opcode enum (NOP..LDI)
  - FSM state enum
  - instruction field bit positions and widths
- One sub-module, regfile_ctrl_alu: purely combinational, (op, a, b, imm) -> {carry, result}. It is instantiated once in EXEC's datapath.

Test Plan:
All scenarios start from the register file reset state r0 = 0x05, r1 = 0x01.
- ADD r0,r0,r1 -> one write of 0x06 to r0 two cycles after accept; done pulses in that cycle; zero = 0, carry = 0.
- SUB r1,r1,r0 (with r0 = 0x06) -> r1 = 0xFB, carry = 1, zero = 0.
- LDI r0,0xFF then ADD r0,r0,r1 (r1 = 0x01) -> r0 = 0x00, zero = 1, carry = 1. The following XOR r1,r1,r1 -> r1 = 0x00, zero = 1, carry = 0.
- Back-to-back valid held high for 3 instructions -> instr_ready pulses once per 3 cycles, exactly 3 done pulses, and no instruction dropped or duplicated.
- NOP -> done pulses; rf_write_enable never asserts; result and flags are unchanged.
- reset asserted during WB of an ADD -> no write strobe that cycle; next cycle state is IDLE with busy = 0 and all outputs at reset values.
